// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: register-address width, op latencies and the
// register-index type used by the ID-stage hazard logic.
package riscv_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // Cycles before a result is forwardable; 0 means the result is never tracked.
  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;
  localparam int unsigned LAT_MUL  = 3;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/id_scoreboard_sb_counter.sv
// One scoreboard entry: a down-counter of pending result latency.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   i_freeze    - backend hold; keeps the count unchanged
//   i_clear     - squashed producer releases the register
//   i_load      - accepted producer of this register; loads i_load_val
//   i_load_val  - latency of the new producer
//   o_cnt       - remaining cycles before the result is forwardable
module sb_counter
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_freeze,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Priority: reset, freeze, clear, load (newer producer wins), count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_freeze) begin
      r_cnt <= r_cnt;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage load-use / multi-cycle hazard unit built on a per-register
// countdown scoreboard.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   rs1Addr_id, rs2Addr_id    - source registers of the instruction in ID
//   rs1_used, rs2_used        - decoder-qualified source usage
//   issue_valid, issue_rd     - instruction in ID requests EX, its destination
//   issue_lat                 - result latency (0 = untracked ALU op)
//   hold                      - backend stall; freezes all state
//   flush                     - squash EX and ID instructions
//   Stall / IFWrite           - bubble into ID/EX and hold PC, IF/ID
//   busy_mask                 - per-register pending-result flags
module id_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned CNT_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rs1Addr_id,
  input  logic [ADDR_W-1:0]   rs2Addr_id,
  input  logic                rs1_used,
  input  logic                rs2_used,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic [CNT_W-1:0]    issue_lat,
  input  logic                hold,
  input  logic                flush,
  output logic                Stall,
  output logic                IFWrite,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [CNT_W-1:0]  w_cnt [NUM_REGS];
  logic              w_hit1;
  logic              w_hit2;
  logic              w_acc;
  logic              w_track;
  logic              r_ex_valid;
  logic [ADDR_W-1:0] r_ex_rd;

  // x0 is hardwired and never tracked.
  assign w_cnt[0]     = '0;
  assign busy_mask[0] = 1'b0;

  // Source hazards; x0 maps to the constant-zero entry so it never stalls.
  assign w_hit1  = rs1_used & (rs1Addr_id != '0) & (w_cnt[rs1Addr_id] != '0);
  assign w_hit2  = rs2_used & (rs2Addr_id != '0) & (w_cnt[rs2Addr_id] != '0);
  assign Stall   = hold | w_hit1 | w_hit2;
  assign IFWrite = ~Stall;

  assign w_acc   = issue_valid & ~Stall & ~flush;
  assign w_track = w_acc & (issue_rd != '0) & (issue_lat != '0);

  // Producer currently in EX, so a flush can release its register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_rd    <= '0;
    end else if (!hold) begin
      r_ex_valid <= w_track;
      r_ex_rd    <= issue_rd;
    end
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    logic w_clear;
    logic w_load;

    assign w_clear = flush & r_ex_valid & (r_ex_rd == ADDR_W'(g));
    assign w_load  = w_track & (issue_rd == ADDR_W'(g));

    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_freeze   (hold),
      .i_clear    (w_clear),
      .i_load     (w_load),
      .i_load_val (issue_lat),
      .o_cnt      (w_cnt[g])
    );

    assign busy_mask[g] = (w_cnt[g] != '0);
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench: each driven cycle pushes the expected Stall/busy_mask
// from a ready-time reference model; a monitor pops and compares.
module tb_id_scoreboard;
  import riscv_pipe_pkg::*;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned CNT_W    = 3;

  logic                clk;
  logic                rst;
  logic [ADDR_W-1:0]   rs1Addr_id;
  logic [ADDR_W-1:0]   rs2Addr_id;
  logic                rs1_used;
  logic                rs2_used;
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_rd;
  logic [CNT_W-1:0]    issue_lat;
  logic                hold;
  logic                flush;
  logic                Stall;
  logic                IFWrite;
  logic [NUM_REGS-1:0] busy_mask;

  id_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1Addr_id  (rs1Addr_id),
    .rs2Addr_id  (rs2Addr_id),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_lat   (issue_lat),
    .hold        (hold),
    .flush       (flush),
    .Stall       (Stall),
    .IFWrite     (IFWrite),
    .busy_mask   (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic                stall;
    logic [NUM_REGS-1:0] mask;
    int                  cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: absolute cycle at which each register becomes readable.
  // A register is busy during cycle c when ready_at[r] > c.
  int   ready_at [NUM_REGS];
  int   cyc = 0;
  bit   m_ex_valid = 1'b0;
  int   m_ex_rd = 0;

  function automatic bit m_busy(int r);
    return (r != 0) && (ready_at[r] > cyc);
  endfunction

  // Drive one cycle, push the expectation, then advance the model by one edge.
  task automatic step(input bit r_rst, input int s1, input bit u1, input int s2, input bit u2,
                      input bit iv, input int rd, input int lat, input bit hd, input bit fl);
    exp_t e;
    bit   acc;
    @(negedge clk);
    rst = r_rst; rs1Addr_id = ADDR_W'(s1); rs1_used = u1; rs2Addr_id = ADDR_W'(s2);
    rs2_used = u2; issue_valid = iv; issue_rd = ADDR_W'(rd); issue_lat = CNT_W'(lat);
    hold = hd; flush = fl;
    e.stall = hd | (u1 & m_busy(s1)) | (u2 & m_busy(s2));
    for (int r = 0; r < int'(NUM_REGS); r++) e.mask[r] = m_busy(r);
    e.cyc = cyc;
    exp_q.push_back(e);
    acc = iv & ~e.stall & ~fl;
    if (r_rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) ready_at[r] = 0;
      m_ex_valid = 1'b0;
      m_ex_rd = 0;
    end else if (hd) begin
      // Frozen counts: every pending release slips by one cycle.
      for (int r = 1; r < int'(NUM_REGS); r++) if (ready_at[r] > cyc) ready_at[r]++;
    end else begin
      if (fl && m_ex_valid) ready_at[m_ex_rd] = cyc;
      if (acc && rd != 0 && lat != 0) ready_at[rd] = cyc + 1 + lat;
      m_ex_valid = acc && rd != 0 && lat != 0;
      m_ex_rd = rd;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: sample just before the rising edge, outputs settled.
  always @(negedge clk) begin
    #4;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (Stall !== e.stall) begin
        errors++;
        $display("FAIL stall cyc=%0d got=%b exp=%b", e.cyc, Stall, e.stall);
      end
      checks++;
      if (IFWrite !== ~e.stall) begin
        errors++;
        $display("FAIL ifwrite cyc=%0d got=%b exp=%b", e.cyc, IFWrite, ~e.stall);
      end
      checks++;
      if (busy_mask !== e.mask) begin
        errors++;
        $display("FAIL busy_mask cyc=%0d got=%h exp=%h", e.cyc, busy_mask, e.mask);
      end
    end
  end

  initial begin
    int s1, s2, rd, lat;
    rst = 1'b1; rs1Addr_id = '0; rs2Addr_id = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_lat = '0; hold = 1'b0; flush = 1'b0;
    for (int r = 0; r < int'(NUM_REGS); r++) ready_at[r] = 0;

    // Reset, load x5, dependent add x6,x5,x1 stalls one cycle.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5, LAT_LOAD, 0, 0);
    step(0, 5, 1, 1, 1, 1, 6, LAT_ALU, 0, 0);
    step(0, 5, 1, 1, 1, 1, 6, LAT_ALU, 0, 0);
    idle(2);
    // mul x7, reader on rs2: three bubbles; then same with rs2_used=0.
    step(0, 0, 0, 0, 0, 1, 7, LAT_MUL, 0, 0);
    repeat (4) step(0, 1, 1, 7, 1, 1, 8, LAT_ALU, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1, 7, LAT_MUL, 0, 0);
    repeat (4) step(0, 1, 1, 7, 0, 1, 8, LAT_ALU, 0, 0);
    idle(4);
    // Load x5 then hold for three cycles: dependent stalls after the hold too.
    step(0, 0, 0, 0, 0, 1, 5, LAT_LOAD, 0, 0);
    repeat (3) step(0, 5, 1, 0, 0, 1, 6, LAT_ALU, 1, 0);
    repeat (2) step(0, 5, 1, 0, 0, 1, 6, LAT_ALU, 0, 0);
    idle(2);
    // Load x9 lat=2, flush next cycle with a competing issue, reader then free.
    step(0, 0, 0, 0, 0, 1, 9, 2, 0, 0);
    step(0, 0, 0, 0, 0, 1, 10, LAT_MUL, 0, 1);
    step(0, 9, 1, 10, 1, 1, 11, LAT_ALU, 0, 0);
    idle(2);
    // x0 is never tracked nor stalls; WAW on x4.
    step(0, 0, 0, 0, 0, 1, 0, LAT_LOAD, 0, 0);
    step(0, 0, 1, 0, 1, 1, 3, LAT_ALU, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4, LAT_MUL, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4, LAT_ALU, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4, LAT_LOAD, 0, 0);
    idle(3);
    // Reset mid-stall with cnt[8]=3.
    step(0, 0, 0, 0, 0, 1, 8, LAT_MUL, 0, 0);
    step(1, 8, 1, 0, 0, 1, 2, LAT_ALU, 0, 0);
    step(0, 8, 1, 0, 0, 1, 2, LAT_ALU, 0, 0);
    idle(2);
    // Maximum latency.
    step(0, 0, 0, 0, 0, 1, 12, 7, 0, 0);
    repeat (9) step(0, 12, 1, 0, 0, 1, 13, LAT_ALU, 0, 0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      s1  = int'($urandom_range(0, 7));
      s2  = int'($urandom_range(0, 7));
      rd  = int'($urandom_range(0, 7));
      lat = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 7));
      step($urandom_range(0, 99) < 2, s1, $urandom_range(0, 3) != 0, s2, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 7, rd, lat, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    // Drain outstanding expectations with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Parametrised load-use / multi-cycle hazard unit for the ID stage of the five-stage RISC-V pipeline.
- Replaces the single-cycle "rdAddr_ex matches rs and MemRead_ex" check with a per-register countdown scoreboard.
- Supports loads and multi-cycle ops of configurable latency, backend hold (slow memory) and EX-stage flush.
- Drives Stall/IFWrite to the IF/ID registers and the ID/EX bubble insertion.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never tracked.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- CNT_W, 3, counter width; maximum tracked latency is 2**CNT_W-1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1Addr_id  in  ADDR_W  rs1 of instruction in ID.
- rs2Addr_id  in  ADDR_W  rs2 of instruction in ID.
- rs1_used  in  1  instruction in ID reads rs1 (decoder-qualified).
- rs2_used  in  1  instruction in ID reads rs2.
- issue_valid  in  1  instruction in ID is valid and requests to move to EX this cycle.
- issue_rd  in  ADDR_W  destination of issuing instruction.
- issue_lat  in  CNT_W  cycles before its result is forwardable. 0 = ALU op, not tracked; 1 = classic load.
- hold  in  1  backend stalled (memory not ready); freezes the scoreboard.
- flush  in  1  squash the instruction currently in EX and the one in ID (taken branch/jump).
- Stall  out  1  insert bubble into ID/EX; hold PC and IF/ID.
- IFWrite  out  1  ~Stall.
- busy_mask  out  NUM_REGS  bit r = cnt[r] != 0; debug/perf only.

Behaviour:
- State:
  - cnt[1..NUM_REGS-1], CNT_W bits each.
  - ex_rd (ADDR_W) and ex_valid (1): the tracked instruction issued last cycle.
- Reset (rst=1 at edge): all cnt=0, ex_valid=0, ex_rd=0. Outputs next cycle: Stall=0, IFWrite=1, busy_mask=0.
- Stall (combinational from registered state, 0-cycle latency):
  - Stall = hold | (rs1_used & rs1Addr_id!=0 & cnt[rs1Addr_id]!=0) | (rs2_used & rs2Addr_id!=0 & cnt[rs2Addr_id]!=0).
- Accepted issue: acc = issue_valid & ~Stall & ~flush.
- Per-edge update for each register r, highest priority first:
  1. rst: cnt[r]=0.
  2. hold: no change to any state.
  3. flush & ex_valid & r==ex_rd: cnt[r]=0 (squashed producer releases its register).
  4. acc & issue_rd==r & r!=0 & issue_lat!=0: cnt[r]=issue_lat. Overwrites any pending value (in-order WAW; the newer producer governs).
  5. cnt[r]!=0: cnt[r]=cnt[r]-1.
- ex tracking: when not hold, ex_valid <= acc & issue_rd!=0 & issue_lat!=0 and ex_rd <= issue_rd; cleared by flush.
- Timing: a load (lat=1) issued at cycle t stalls a dependent in ID during t+1 only. This gives the single bubble of the original design. Latency L gives L bubbles.
- Boundaries:
  - issue_lat=0 or issue_rd=0: no state change.
  - rs=0 never stalls.
  - Hold during a pending count extends the stall by the hold duration.
  - Flush and issue in the same cycle: the issue is ignored.
  - Counter saturation is impossible because loads only write values up to 2**CNT_W-1.
  - rst mid-stall clears the stall on the next cycle.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - reg-address width constant.
  - latency constants: LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3.
  - Type for a register index.
- Natural sub-module: sb_counter. One CNT_W down-counter with load/clear/freeze, instantiated NUM_REGS-1 times via generate.

Test Plan:
- Reset, then a load x5 lat=1 at cycle 1; add x6,x5,x1 in ID at cycle 2 -> Stall=1, IFWrite=0 at cycle 2; Stall=0 at cycle 3; busy_mask[5] 1 at cycle 2, 0 at cycle 3.
- mul x7 lat=3 at cycle 1; dependent reading rs2=x7 -> Stall high at cycles 2,3,4, low at cycle 5. Same case with rs2_used=0 -> never stalls.
- load x5 lat=1, then hold=1 for cycles 2-4 -> Stall=1 cycles 2-4; cnt[5] stays 1; dependent stalls at cycle 5 and proceeds at cycle 6.
- load x9 lat=2 issued at cycle 1; flush=1 at cycle 2 -> cnt[9]=0 at cycle 3; issue_valid during the flush is ignored; a reader of x9 at cycle 3 -> Stall=0.
- load x0 lat=1 and a reader of x0 -> no stall. WAW: mul x4 lat=3 at cycle 1, ALU x4 lat=0 is not tracked, load x4 lat=1 at cycle 3 -> cnt[4]=1 at cycle 4, then 0.
- rst=1 asserted at cycle 2 while cnt[8]=3 -> Stall=0 and busy_mask=0 from cycle 3.
